// File: rtl/mac_video_capture.sv
// Video capture for palcl outputs: windowed 1-bit sampling, MSB-first byte packing
// into a small registered-head FIFO, plus line-length and frame-length measurement.
module mac_video_capture #(
  parameter int unsigned H_START  = 0,
  parameter int unsigned H_ACTIVE = 512,
  parameter int unsigned V_START  = 0,
  parameter int unsigned V_ACTIVE = 342,
  parameter int unsigned DEPTH    = 4
) (
  input  logic       simclk,
  input  logic       n_res,
  input  logic       pclk,
  input  logic       vid,
  input  logic       n_hsync,
  input  logic       n_vsync,
  output logic [7:0] px_data,
  output logic       px_sof,
  output logic       px_eol,
  output logic       px_valid,
  input  logic       px_ready,
  output logic       overflow,
  output logic [9:0] line_len,
  output logic [8:0] frame_lines
);

  localparam int unsigned CW = $clog2(DEPTH);
  localparam int unsigned EW = 10;

  logic          pclk_q, hs_q, vs_q;
  logic          pclk_rise, hs_fall, hs_rise, vs_fall;
  logic [9:0]    hcount, lcount;
  logic [8:0]    vcount;
  logic [7:0]    shreg;
  logic [2:0]    idx;

  logic [9:0]    px_pos;
  logic [8:0]    vpos;
  logic [2:0]    idx_base;
  logic          in_win, capture, push;
  logic [EW-1:0] entry;

  // FIFO: one registered head plus DEPTH-1 backing entries
  logic [EW-1:0] mem [DEPTH-1];
  logic [CW-1:0] rd, wr, cnt;
  logic          pop, full, mem_we, load_new, load_mem;

  assign pclk_rise = ~pclk_q & pclk;
  assign hs_fall   = hs_q & ~n_hsync;
  assign hs_rise   = ~hs_q & n_hsync;
  assign vs_fall   = vs_q & ~n_vsync;

  function automatic logic [CW-1:0] nxt(input logic [CW-1:0] p);
    return (p == CW'(DEPTH - 2)) ? '0 : p + 1'b1;
  endfunction

  // A pclk coinciding with hs_rise is pixel 0 of the new line
  always_comb begin
    px_pos   = hs_rise ? 10'd0 : hcount;
    vpos     = vs_fall ? 9'd0 : vcount;
    idx_base = (hs_rise | vs_fall) ? 3'd0 : idx;
    in_win   = (32'(px_pos) + 32'd1 > H_START) && (32'(px_pos) < H_START + H_ACTIVE) &&
               (32'(vpos) + 32'd1 > V_START) && (32'(vpos) < V_START + V_ACTIVE);
    capture  = pclk_rise & in_win;
    push     = capture & (idx_base == 3'd7);
    entry    = {(32'(vpos) == V_START) && (32'(px_pos) == H_START + 32'd7),
                32'(px_pos) == H_START + H_ACTIVE - 32'd1,
                shreg[6:0], vid};
  end

  always_comb begin
    pop      = px_valid & px_ready;
    full     = px_valid & (cnt == CW'(DEPTH - 1));
    load_mem = pop & (cnt != '0);
    load_new = push & (~px_valid | (pop & (cnt == '0)));
    mem_we   = push & px_valid & (pop ? (cnt != '0) : ~full);
  end

  always_ff @(posedge simclk or negedge n_res) begin
    if (!n_res) begin
      pclk_q      <= 1'b1;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      hcount      <= '0;
      lcount      <= '0;
      vcount      <= '0;
      shreg       <= '0;
      idx         <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      pclk_q <= pclk;
      hs_q   <= n_hsync;
      vs_q   <= n_vsync;

      if (hs_rise)                                hcount <= pclk_rise ? 10'd1 : 10'd0;
      else if (pclk_rise && hcount != 10'h3FF)    hcount <= hcount + 10'd1;

      if (hs_fall) begin
        line_len <= lcount;
        lcount   <= pclk_rise ? 10'd1 : 10'd0;
      end else if (pclk_rise && lcount != 10'h3FF) begin
        lcount <= lcount + 10'd1;
      end

      if (vs_fall) begin
        frame_lines <= vcount;
        vcount      <= '0;
      end else if (hs_fall && vcount != 9'h1FF) begin
        vcount <= vcount + 9'd1;
      end

      if (capture) begin
        shreg <= entry[7:0];
        idx   <= idx_base + 3'd1;
      end else begin
        idx   <= idx_base;
      end
    end
  end

  always_ff @(posedge simclk or negedge n_res) begin
    if (!n_res) begin
      {px_sof, px_eol, px_data} <= '0;
      px_valid <= 1'b0;
      overflow <= 1'b0;
      rd       <= '0;
      wr       <= '0;
      cnt      <= '0;
    end else begin
      if (load_mem) begin
        {px_sof, px_eol, px_data} <= mem[rd];
        rd <= nxt(rd);
      end else if (load_new) begin
        {px_sof, px_eol, px_data} <= entry;
        px_valid <= 1'b1;
      end else if (pop) begin
        px_valid <= 1'b0;
      end

      if (mem_we) wr <= nxt(wr);
      if (mem_we && !load_mem)      cnt <= cnt + 1'b1;
      else if (load_mem && !mem_we) cnt <= cnt - 1'b1;

      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge simclk) begin
    if (mem_we) mem[wr] <= entry;
  end

endmodule

// File: tb/tb_mac_video_capture.sv
// Directed bench for mac_video_capture: packing, tagging, timing counters,
// backpressure/overflow, sync coincidence, partial bytes and mid-line reset.
module tb_mac_video_capture;

  logic       simclk, n_res, pclk, vid, n_hsync, n_vsync, px_ready;
  logic [7:0] px_data;
  logic       px_sof, px_eol, px_valid, overflow;
  logic [9:0] line_len;
  logic [8:0] frame_lines;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [7:0] data;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  mac_video_capture dut (
    .simclk(simclk), .n_res(n_res), .pclk(pclk), .vid(vid),
    .n_hsync(n_hsync), .n_vsync(n_vsync),
    .px_data(px_data), .px_sof(px_sof), .px_eol(px_eol),
    .px_valid(px_valid), .px_ready(px_ready), .overflow(overflow),
    .line_len(line_len), .frame_lines(frame_lines)
  );

  initial simclk = 1'b0;
  always #5 simclk = ~simclk;

  // Inputs change 1 unit after posedge, so at negedge they match the next edge's handshake
  always @(negedge simclk) begin
    if (n_res && px_valid && px_ready) q.push_back({px_sof, px_eol, px_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge simclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(input logic v);
    vid = v; pclk = 1'b1; tick();
    pclk = 1'b0; tick();
  endtask

  task automatic put_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) pix(b[i]);
  endtask

  task automatic hs_pulse();
    n_hsync = 1'b0; tick();
    n_hsync = 1'b1; tick();
  endtask

  int          bad;
  logic [7:0]  pat;

  initial begin
    n_res = 1'b0; pclk = 1'b0; vid = 1'b0;
    n_hsync = 1'b1; n_vsync = 1'b1; px_ready = 1'b1;
    idle(3);
    chk("rst_valid", 32'(px_valid), 32'd0);
    chk("rst_data", 32'(px_data), 32'd0);
    chk("rst_sof", 32'(px_sof), 32'd0);
    chk("rst_eol", 32'(px_eol), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_line_len", 32'(line_len), 32'd0);
    chk("rst_frame_lines", 32'(frame_lines), 32'd0);
    n_res = 1'b1;
    idle(2);

    // Packing: vsync falls inside hsync, then one full line of 0xB1 pattern
    n_hsync = 1'b0; tick();
    n_vsync = 1'b0; tick();
    n_vsync = 1'b1; n_hsync = 1'b1; tick();
    chk("pk_frame_lines", 32'(frame_lines), 32'd1);
    pat = 8'hB1;
    for (int b = 0; b < 64; b++) put_byte(pat);
    put_byte(8'hFF);
    idle(4);
    chk("pk_count", 32'(q.size()), 32'd64);
    bad = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].data != 8'hB1 || q[i].sof != (i == 0) || q[i].eol != (i == 63)) bad++;
    end
    chk("pk_bad_bytes", 32'(bad), 32'd0);
    chk("pk_sof0", 32'(q[0].sof), 32'd1);
    chk("pk_eol63", 32'(q[63].eol), 32'd1);
    q.delete();

    // Partial byte discarded; next line realigns to pixel 0
    hs_pulse();
    for (int i = 0; i < 5; i++) pix(1'b1);
    hs_pulse();
    idle(2);
    chk("pt_none", 32'(q.size()), 32'd0);
    put_byte(8'h4D);
    idle(3);
    chk("pt_count", 32'(q.size()), 32'd1);
    chk("pt_data", 32'(q[0].data), 32'h4D);
    chk("pt_sof", 32'(q[0].sof), 32'd0);
    q.delete();

    // Coincident vsync/hsync fall: old count latched, next line is frame start
    n_hsync = 1'b0; n_vsync = 1'b0; tick();
    chk("sim_frame_lines", 32'(frame_lines), 32'd2);
    n_hsync = 1'b1; n_vsync = 1'b1; tick();
    put_byte(8'hF0);
    idle(3);
    chk("sim_count", 32'(q.size()), 32'd1);
    chk("sim_data", 32'(q[0].data), 32'hF0);
    chk("sim_sof", 32'(q[0].sof), 32'd1);
    q.delete();

    // Timing: 370 lines per frame, last two lines carry 704 pclks
    n_vsync = 1'b0; tick();
    n_vsync = 1'b1; tick();
    for (int k = 0; k < 370; k++) begin
      hs_pulse();
      for (int p = 0; p < ((k >= 368) ? 704 : 2); p++) pix(1'b0);
    end
    n_vsync = 1'b0; tick();
    n_vsync = 1'b1; tick();
    chk("tm_line_len", 32'(line_len), 32'd704);
    chk("tm_frame_lines", 32'(frame_lines), 32'd370);
    q.delete();

    // Backpressure: whole line with ready low, head held, overflow sticky
    px_ready = 1'b0;
    hs_pulse();
    for (int b = 0; b < 64; b++) put_byte(8'(b + 8'h30));
    idle(2);
    chk("bp_valid", 32'(px_valid), 32'd1);
    chk("bp_head", 32'(px_data), 32'h30);
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_none_popped", 32'(q.size()), 32'd0);
    idle(5);
    chk("bp_head_stable", 32'(px_data), 32'h30);
    px_ready = 1'b1;
    idle(8);
    chk("bp_drained", 32'(q.size()), 32'd4);
    for (int j = 0; j < 4; j++) chk($sformatf("bp_order%0d", j), 32'(q[j].data), 32'(8'h30 + j));
    chk("bp_empty", 32'(px_valid), 32'd0);
    q.delete();

    // Mid-line reset with two bytes buffered
    px_ready = 1'b0;
    hs_pulse();
    put_byte(8'hAA);
    put_byte(8'h55);
    for (int i = 0; i < 3; i++) pix(1'b1);
    chk("mr_pre_valid", 32'(px_valid), 32'd1);
    n_res = 1'b0;
    #5;
    chk("mr_valid", 32'(px_valid), 32'd0);
    chk("mr_data", 32'(px_data), 32'd0);
    chk("mr_ovf", 32'(overflow), 32'd0);
    chk("mr_line_len", 32'(line_len), 32'd0);
    chk("mr_frame_lines", 32'(frame_lines), 32'd0);
    #13;
    n_res = 1'b1;
    px_ready = 1'b1;
    idle(4);
    chk("mr_post_valid", 32'(px_valid), 32'd0);
    chk("mr_post_none", 32'(q.size()), 32'd0);
    hs_pulse();
    put_byte(8'h5A);
    idle(3);
    chk("mr_new_count", 32'(q.size()), 32'd1);
    chk("mr_new_data", 32'(q[0].data), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
